// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// Owner encodings and arbitration-mode constants are also used by the bus top level.
package mem_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    typedef enum logic [1:0] {
        ARB_OWNER_NONE = 2'd0,
        ARB_OWNER_CPU  = 2'd1,
        ARB_OWNER_DMA  = 2'd2
    } arb_owner_e;

    // Only meaningful when at least one request is present.
    function automatic arb_owner_e pick_winner(
        input logic       cpu_req,
        input logic       dma_req,
        input arb_owner_e last_grant,
        input int         mode
    );
        arb_owner_e winner;
        winner = ARB_OWNER_CPU;
        if (cpu_req && dma_req) begin
            if (mode == ARB_MODE_RR && last_grant == ARB_OWNER_CPU)
                winner = ARB_OWNER_DMA;
        end else if (dma_req) begin
            winner = ARB_OWNER_DMA;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Merges the CPU and DMA memory ports onto one shared data-memory port,
// one outstanding transaction at a time, with a response timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          ARB_MODE    = ARB_MODE_RR,
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_mem_req,
    input  logic              cpu_mem_we,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [XLEN-1:0]   cpu_mem_wdata,
    output logic [XLEN-1:0]   cpu_mem_rdata,
    output logic              cpu_mem_ready,

    input  logic              dma_mem_req,
    input  logic              dma_mem_we,
    input  logic [ADDR_W-1:0] dma_mem_addr,
    input  logic [XLEN-1:0]   dma_mem_wdata,
    output logic [XLEN-1:0]   dma_mem_rdata,
    output logic              dma_mem_ready,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,

    output logic              arb_err
);

    localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [XLEN-1:0]  ERR_DATA = XLEN'(ERR_RDATA);
    localparam bit               TO_EN    = (TIMEOUT_CYC > 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e            r_state;
    arb_owner_e        r_owner;
    arb_owner_e        r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;

    logic              w_busy;
    logic              w_timeout;
    logic              w_done;
    logic [XLEN-1:0]   w_rdata;
    arb_owner_e        w_winner;

    assign w_busy    = (r_state == ST_BUSY);
    // A real response in the same cycle as the timeout always takes precedence.
    assign w_timeout = TO_EN && w_busy && !mem_ready && (r_cnt == CNT_LAST);
    assign w_done    = w_busy && (mem_ready || w_timeout);
    assign w_rdata   = mem_ready ? mem_rdata : ERR_DATA;
    assign w_winner  = pick_winner(cpu_mem_req, dma_mem_req, r_last_grant, ARB_MODE);

    // NOTE: every register here is a plain flop (no memory array), so all of
    // them, including the latched request fields, take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= ARB_OWNER_NONE;
            r_last_grant <= ARB_OWNER_DMA;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees the pre-edge state.
            case (r_state)
                ST_IDLE: begin
                    if (cpu_mem_req || dma_mem_req) begin
                        r_state      <= ST_BUSY;
                        r_owner      <= w_winner;
                        r_last_grant <= w_winner;
                        r_cnt        <= '0;
                        if (w_winner == ARB_OWNER_DMA) begin
                            r_we    <= dma_mem_we;
                            r_addr  <= dma_mem_addr;
                            r_wdata <= dma_mem_wdata;
                        end else begin
                            r_we    <= cpu_mem_we;
                            r_addr  <= cpu_mem_addr;
                            r_wdata <= cpu_mem_wdata;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        r_owner <= ARB_OWNER_NONE;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Shared port comes only from the latches, so master input changes mid-transaction are ignored.
    assign mem_req       = w_busy;
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;

    assign cpu_mem_ready = w_done && (r_owner == ARB_OWNER_CPU);
    assign dma_mem_ready = w_done && (r_owner == ARB_OWNER_DMA);
    assign cpu_mem_rdata = cpu_mem_ready ? w_rdata : '0;
    assign dma_mem_rdata = dma_mem_ready ? w_rdata : '0;
    assign arb_err       = w_timeout;

endmodule
